pattern_rotator: RTL and testbench
==================================

PATTERN_ROTATOR -- requirements
Module: pattern_rotator

Interface
REQ-001 Parameter WIDTH, default 4, is the pattern width in bits (legal range 2..32).
REQ-002 Parameter DIV, default 25000, is the number of enabled clk cycles per step (legal range 1..65535).
REQ-003 Parameter INIT, default 4'b1000 (MSB one-hot for WIDTH), is the pattern value loaded on reset.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  prescaler enable; prescaler and pattern freeze when low.
REQ-008 dir  input  1  1 = rotate left (toward MSB), 0 = rotate right.
REQ-009 mode  input  1  0 = rotate, 1 = bounce.
REQ-010 load  input  1  synchronous pattern load strobe.
REQ-011 load_val  input  WIDTH  pattern value applied on load.
REQ-012 out  output  WIDTH  registered current pattern.
REQ-013 tick  output  1  registered pulse, high for exactly the cycle in which out shows a freshly stepped value.

Function
REQ-014 The prescaler counter SHALL be $clog2(DIV)+1 bits wide, count 0..DIV-1 while en=1, and hold its value while en=0.
REQ-015 A step SHALL occur on an edge where en=1, load=0, and counter==DIV-1; counter then returns to 0; otherwise counter increments.
REQ-016 On a rotate-left step, out[i]<=out[i-1] for i>0 and out[0]<=out[WIDTH-1]; a rotate-right step is the mirror operation.
REQ-017 In mode 0, each step SHALL rotate in the direction given by dir, sampled on the step edge.
REQ-018 In mode 1, each step SHALL rotate in the direction held by an internal register bdir.
REQ-019 In mode 1, when the stepped value has bit WIDTH-1 set (moving left) or bit 0 set (moving right), bdir SHALL invert on the same edge.
REQ-020 bdir SHALL be loaded from dir on load, and SHALL be unaffected by steps in mode 0.
REQ-021 load=1 SHALL take priority over a step on the same edge: out<=load_val, counter<=0, tick<=0.
REQ-022 The step latency SHALL be exactly DIV enabled cycles; with en held high after rst falls, the first step occurs on the DIV-th rising edge.
REQ-023 When DIV=1, a step SHALL occur on every enabled edge and tick SHALL stay high continuously.
REQ-024 A mode change between steps SHALL take effect on the next step with no pattern glitch; the counter SHALL not be cleared.
REQ-025 An all-zero or all-one pattern SHALL rotate unchanged; in mode 1, bdir SHALL still follow REQ-019 (an all-one pattern inverts bdir on every step).

Reset
REQ-026 On a rising edge with rst=1: out<=INIT, counter<=0, tick<=0, bdir<=1 (left); rst overrides load and en.
REQ-027 When reset is asserted mid-count, the partial count SHALL be discarded.

Configuration
REQ-028 With macro PATTERN_ROTATOR_STEP_COUNT_EN defined, the block SHALL add an output step_count (16 bits) that increments by 1 on every step, wraps from 65535 to 0, clears on rst and on load, and does not change on non-step cycles.
REQ-029 Without PATTERN_ROTATOR_STEP_COUNT_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=4, DIV=3, INIT=4'b1000 unless stated)
REQ-030 Rotate-left test: rst for 1 cycle, then en=1, dir=1, mode=0 -> out = 1000,0001,0010,0100,1000, with one step every 3 edges, and tick high only on each step cycle.
REQ-031 Bounce test: mode=1, load=1 with load_val=0001 and dir=1, then en=1 -> out = 0010,0100,1000,0100,0010,0001,0010.
REQ-032 Enable freeze test: en=0 for 10 cycles after 2 enabled counts -> out is unchanged and tick=0; after en returns to 1, the step occurs exactly 1 enabled edge later.
REQ-033 Simultaneous events test: load=1 with load_val=0101 asserted on a step edge -> out=0101, tick=0, and the next step occurs 3 edges later; rst=1 asserted together with load=1 -> out=1000.
REQ-034 DIV=1 test: dir=0 -> out steps right on every edge (1000,0100,0010,0001,1000), and tick is held high.
REQ-035 With PATTERN_ROTATOR_STEP_COUNT_EN defined: after 5 steps step_count=5; after load, step_count=0.

Source files
------------

// File: rtl/pattern_rotator.sv
// pattern_rotator: prescaled rotating/bouncing bit-pattern generator.
//
// Every DIV enabled clock cycles the pattern steps by one bit position. In
// mode 0 it rotates in the direction given by dir. In mode 1 it bounces: it
// rotates in an internal direction bdir that flips when a step lands a one in
// the end bit it is moving toward.
//
// Optional feature: define PATTERN_ROTATOR_STEP_COUNT_EN to add step_count,
// a 16-bit count of steps that wraps and is cleared by rst and load.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, overrides load and en
//   en         in   prescaler enable; counter and pattern hold while low
//   dir        in   1 = rotate left (toward MSB), 0 = rotate right
//   mode       in   0 = rotate, 1 = bounce
//   load       in   synchronous load strobe, wins over a step
//   load_val   in   [WIDTH-1:0] pattern loaded on load
//   out        out  [WIDTH-1:0] registered current pattern
//   tick       out  high for the cycle in which out shows a freshly stepped value
//   step_count out  [15:0] step counter (only with PATTERN_ROTATOR_STEP_COUNT_EN)
module pattern_rotator #(
  parameter int unsigned       WIDTH = 4,
  parameter int unsigned       DIV   = 25000,
  parameter logic [WIDTH-1:0]  INIT  = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick
`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
  ,
  output logic [15:0]      step_count
`endif
);

  localparam int unsigned CntW = $clog2(DIV) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             bdir_q, bdir_d;
  logic             step;
  logic             step_left;
  logic [WIDTH-1:0] rot_val;

  assign step      = en && !load && (cnt_q == CntMax);
  // Bounce mode follows the internal direction; rotate mode follows dir.
  assign step_left = mode ? bdir_q : dir;
  assign rot_val   = step_left ? {out_q[WIDTH-2:0], out_q[WIDTH-1]}
                               : {out_q[0], out_q[WIDTH-1:1]};

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    bdir_d = bdir_q;
    if (load) begin
      out_d  = load_val;
      cnt_d  = '0;
      bdir_d = dir;
    end else if (en) begin
      if (step) begin
        cnt_d  = '0;
        out_d  = rot_val;
        tick_d = 1'b1;
        // Reverse once the moving end bit is reached; all-ones flips every step.
        if (mode && ((step_left && rot_val[WIDTH-1]) || (!step_left && rot_val[0]))) begin
          bdir_d = ~bdir_q;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= INIT;
      tick_q <= 1'b0;
      bdir_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      bdir_q <= bdir_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;

`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
  logic [15:0] step_count_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      step_count_q <= '0;
    end else if (step) begin
      step_count_q <= step_count_q + 16'd1;
    end
  end

  assign step_count = step_count_q;
`endif

endmodule

// File: tb/tb_pattern_rotator.sv
// Self-checking bench for pattern_rotator: a DIV=3 instance (u_dut) and a DIV=1
// instance (u_dut1). Expected values are queued when stimulus is applied at the
// falling edge and popped/compared just after the following rising edge.
module tb_pattern_rotator;

  logic       clk;
  logic       rst, en, dir, mode, load;
  logic [3:0] load_val, out0;
  logic       tick0;
  logic       rst1, en1, dir1, mode1, load1;
  logic [3:0] load_val1, out1;
  logic       tick1;
`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
  logic [15:0] sc0, sc1;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string       tag;
    int          unit;  // 0 = u_dut, 1 = u_dut1
    int          kind;  // 0 = out, 1 = tick, 2 = step_count
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];

  pattern_rotator #(.WIDTH(4), .DIV(3), .INIT(4'b1000)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .out      (out0),
    .tick     (tick0)
`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
    ,
    .step_count (sc0)
`endif
  );

  pattern_rotator #(.WIDTH(4), .DIV(1), .INIT(4'b1000)) u_dut1 (
    .clk      (clk),
    .rst      (rst1),
    .en       (en1),
    .dir      (dir1),
    .mode     (mode1),
    .load     (load1),
    .load_val (load_val1),
    .out      (out1),
    .tick     (tick1)
`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
    ,
    .step_count (sc1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int unit, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.unit = unit;
    e.kind = kind;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic exp_pat(input string tag, input int unit, input logic [3:0] o, input logic t);
    push({tag, ".out"}, unit, 0, 32'(o));
    push({tag, ".tick"}, unit, 1, 32'(t));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: drain everything queued for the edge that just happened.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = exp_q.pop_front();
      got = '0;
      case (e.kind)
        0: got = 32'(e.unit == 0 ? out0 : out1);
        1: got = 32'(e.unit == 0 ? tick0 : tick1);
`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
        2: got = 32'(e.unit == 0 ? sc0 : sc1);
`endif
        default: got = 32'hdead_beef;
      endcase
      check_eq(e.tag, got, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] left_pats[4]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] right_pats[4]  = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [3:0] bounce_pats[7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010};
    logic [3:0] cur;
    int n;

    rst = 1'b1; en = 1'b0; dir = 1'b1; mode = 1'b0; load = 1'b0; load_val = '0;
    rst1 = 1'b1; en1 = 1'b0; dir1 = 1'b0; mode1 = 1'b0; load1 = 1'b0; load_val1 = '0;
    @(negedge clk);

    // Reset, with load and en also high: reset must win.
    en = 1'b1; load = 1'b1; load_val = 4'b0110;
    exp_pat("reset", 0, 4'b1000, 1'b0);
    exp_pat("reset1", 1, 4'b1000, 1'b0);
    cyc();

    // Rotate left, DIV=3; DIV=1 instance steps right every edge alongside.
    rst = 1'b0; en = 1'b1; dir = 1'b1; mode = 1'b0; load = 1'b0;
    rst1 = 1'b0; en1 = 1'b1;
    cur = 4'b1000;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= 3; k++) begin
        if (k == 3) cur = left_pats[i];
        exp_pat("rotl", 0, cur, k == 3);
        exp_pat("div1", 1, right_pats[n % 4], 1'b1);
        n++;
        cyc();
      end
    end
    en1 = 1'b0;

    // Enable freeze: two counts, ten frozen cycles, then one edge to step.
    for (int k = 0; k < 2; k++) begin
      exp_pat("pre_freeze", 0, 4'b1000, 1'b0);
      cyc();
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_pat("freeze", 0, 4'b1000, 1'b0);
      cyc();
    end
    en = 1'b1;
    exp_pat("unfreeze", 0, 4'b0001, 1'b1);
`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
    push("step_count5", 0, 2, 32'd5);
`endif
    cyc();

    // Load on a step edge wins; next step three edges later.
    for (int k = 0; k < 2; k++) begin
      exp_pat("pre_load", 0, 4'b0001, 1'b0);
      cyc();
    end
    load = 1'b1; load_val = 4'b0101;
    exp_pat("load_on_step", 0, 4'b0101, 1'b0);
`ifdef PATTERN_ROTATOR_STEP_COUNT_EN
    push("step_count_load", 0, 2, 32'd0);
`endif
    cyc();
    load = 1'b0;
    exp_pat("post_load1", 0, 4'b0101, 1'b0);
    cyc();
    exp_pat("post_load2", 0, 4'b0101, 1'b0);
    cyc();
    exp_pat("post_load_step", 0, 4'b1010, 1'b1);
    cyc();
    rst = 1'b1; load = 1'b1; load_val = 4'b0101;
    exp_pat("rst_and_load", 0, 4'b1000, 1'b0);
    cyc();

    // Bounce: dir low after load proves bdir, not dir, steers the steps.
    rst = 1'b0; en = 1'b0; mode = 1'b1; load = 1'b1; load_val = 4'b0001; dir = 1'b1;
    exp_pat("bounce_load", 0, 4'b0001, 1'b0);
    cyc();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    cur = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      for (int k = 1; k <= 3; k++) begin
        if (k == 3) cur = bounce_pats[i];
        exp_pat("bounce", 0, cur, k == 3);
        cyc();
      end
    end

    // Mode change mid-count: counter kept, new mode used on the next step.
    exp_pat("mode_chg1", 0, 4'b0010, 1'b0);
    cyc();
    mode = 1'b0; dir = 1'b0;
    exp_pat("mode_chg2", 0, 4'b0010, 1'b0);
    cyc();
    exp_pat("mode_chg_step", 0, 4'b0001, 1'b1);
    cyc();

    // All-ones in bounce mode and all-zero in rotate mode stay unchanged.
    mode = 1'b1; dir = 1'b1; load = 1'b1; load_val = 4'b1111;
    exp_pat("ones_load", 0, 4'b1111, 1'b0);
    cyc();
    load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_pat("ones", 0, 4'b1111, k % 3 == 0);
      cyc();
    end
    mode = 1'b0; load = 1'b1; load_val = 4'b0000;
    exp_pat("zero_load", 0, 4'b0000, 1'b0);
    cyc();
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_pat("zero", 0, 4'b0000, k == 3);
      cyc();
    end

    cyc();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
